// File: rtl/rle_encoder.sv
// Quantizing zero-run-length encoder for serialized 8-coefficient DCT frames.
// Build option RLE_ROUND_EN selects round-half-up quantization instead of truncation.

module rle_encoder #(
  parameter int unsigned COEF_W    = 19,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned QSHIFT    = 6,
  parameter int unsigned VAL_W     = 8,
  parameter int unsigned RUN_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_in,
  output logic              coef_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [VAL_W-1:0]  out_val,
  output logic              out_eob,
  output logic              sat
);

  localparam int unsigned RUN_MAX = (1 << RUN_W) - 1;
  localparam int unsigned IDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned SUM_W   = COEF_W + 1;
  localparam int          QMAX_I  = (1 << (VAL_W - 1)) - 1;
  localparam int          QMIN_I  = -(1 << (VAL_W - 1));
  localparam logic signed [SUM_W-1:0] QMAX = SUM_W'(QMAX_I);
  localparam logic signed [SUM_W-1:0] QMIN = SUM_W'(QMIN_I);

  typedef enum logic {
    ACCEPT   = 1'b0,
    EOB_PEND = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [RUN_W-1:0]   run_cnt, run_cnt_d;
  logic               valid_d, eob_d, sat_d;
  logic [RUN_W-1:0]   run_d;
  logic [VAL_W-1:0]   val_d;

  // Quantizer: arithmetic shift (optionally rounded) then clip to VAL_W
  logic signed [SUM_W-1:0] coef_ext;
  logic signed [SUM_W-1:0] q_wide;
  logic                    clip_hi, clip_lo;
  logic [VAL_W-1:0]        q_val;
  logic                    q_zero;

  assign coef_ext = SUM_W'($signed(coef_in));

`ifdef RLE_ROUND_EN
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (QSHIFT - 1);
  logic signed [SUM_W-1:0] round_sum;
  assign round_sum = coef_ext + HALF;
  assign q_wide    = round_sum >>> QSHIFT;
`else
  assign q_wide    = coef_ext >>> QSHIFT;
`endif

  assign clip_hi = (q_wide > QMAX);
  assign clip_lo = (q_wide < QMIN);
  assign q_val   = clip_hi ? VAL_W'(QMAX_I) :
                   clip_lo ? VAL_W'(QMIN_I) : q_wide[VAL_W-1:0];
  assign q_zero  = (q_val == '0);

  // Handshake and frame position
  logic accept, last, run_full, out_free;
  logic [RUN_W-1:0] eob_run;

  assign out_free   = !out_valid || out_ready;
  assign coef_ready = !rst && (state == ACCEPT) && out_free;
  assign accept     = coef_valid && coef_ready;
  assign last       = (idx == IDX_W'(FRAME_LEN - 1));
  assign run_full   = (run_cnt == RUN_W'(RUN_MAX));
  assign eob_run    = run_full ? run_cnt : run_cnt + 1'b1;

  // Next-state and token register load
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    run_cnt_d = run_cnt;
    valid_d   = out_valid && !out_ready;
    run_d     = out_run;
    val_d     = out_val;
    eob_d     = out_eob;
    sat_d     = 1'b0;

    case (state)
      ACCEPT: begin
        if (accept) begin
          sat_d = clip_hi || clip_lo;
          if (last) begin
            idx_d     = '0;
            run_cnt_d = '0;
            valid_d   = 1'b1;
            if (!q_zero) begin
              run_d   = run_cnt;
              val_d   = q_val;
              eob_d   = 1'b0;
              state_d = EOB_PEND;
            end else begin
              run_d   = eob_run;
              val_d   = '0;
              eob_d   = 1'b1;
            end
          end else begin
            idx_d = idx + 1'b1;
            if (!q_zero) begin
              valid_d   = 1'b1;
              run_d     = run_cnt;
              val_d     = q_val;
              eob_d     = 1'b0;
              run_cnt_d = '0;
            end else if (run_full) begin
              // Escape token stands for RUN_MAX+1 zeros
              valid_d   = 1'b1;
              run_d     = RUN_W'(RUN_MAX);
              val_d     = '0;
              eob_d     = 1'b0;
              run_cnt_d = '0;
            end else begin
              run_cnt_d = run_cnt + 1'b1;
            end
          end
        end
      end
      EOB_PEND: begin
        if (out_free) begin
          valid_d = 1'b1;
          run_d   = '0;
          val_d   = '0;
          eob_d   = 1'b1;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      idx       <= '0;
      run_cnt   <= '0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_val   <= '0;
      out_eob   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      run_cnt   <= run_cnt_d;
      out_valid <= valid_d;
      out_run   <= run_d;
      out_val   <= val_d;
      out_eob   <= eob_d;
      sat       <= sat_d;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: directed frames plus random frames against a token-level model.
// Two instances: default FRAME_LEN=8 and FRAME_LEN=16 (exercises escape tokens).

module tb_rle_encoder;

  typedef struct packed {
    logic [2:0] run;
    logic [7:0] val;
    logic       eob;
  } tok_t;

  logic        clk, rst, out_ready;
  logic [18:0] coef_in;
  logic        valid8, rdy8, ov8, eob8, sat8;
  logic [2:0]  run8;
  logic [7:0]  val8;
  logic        valid16, rdy16, ov16, eob16, sat16;
  logic [2:0]  run16;
  logic [7:0]  val16;

  rle_encoder u8 (
    .clk(clk), .rst(rst), .coef_valid(valid8), .coef_in(coef_in), .coef_ready(rdy8),
    .out_valid(ov8), .out_ready(out_ready), .out_run(run8), .out_val(val8),
    .out_eob(eob8), .sat(sat8)
  );

  rle_encoder #(.FRAME_LEN(16)) u16 (
    .clk(clk), .rst(rst), .coef_valid(valid16), .coef_in(coef_in), .coef_ready(rdy16),
    .out_valid(ov16), .out_ready(out_ready), .out_run(run16), .out_val(val16),
    .out_eob(eob16), .sat(sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   stalls;
  int   exp_sat;
  int   sat_base;
  int   satc8 = 0;
  int   satc16 = 0;
  int   frm[$];
  tok_t exp8[$], exp16[$], got8[$], got16[$];
  logic hold8 = 1'b0, hold16 = 1'b0;
  logic [11:0] held8, held16;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Token capture, sat pulse counting and hold-stability checking
  always @(negedge clk) begin
    if (rst) begin
      hold8  <= 1'b0;
      hold16 <= 1'b0;
    end else begin
      if (ov8 && out_ready)  got8.push_back(tok_t'({run8, val8, eob8}));
      if (ov16 && out_ready) got16.push_back(tok_t'({run16, val16, eob16}));
      if (sat8)  satc8  <= satc8 + 1;
      if (sat16) satc16 <= satc16 + 1;
      if (hold8) begin
        check("hold8_valid", ov8, 1);
        check("hold8_tok", {run8, val8, eob8}, held8);
      end
      if (hold16) begin
        check("hold16_valid", ov16, 1);
        check("hold16_tok", {run16, val16, eob16}, held16);
      end
      hold8  <= ov8 && !out_ready;
      held8  <= {run8, val8, eob8};
      hold16 <= ov16 && !out_ready;
      held16 <= {run16, val16, eob16};
    end
  end

  // Reference quantizer: floor((c [+32]) / 64), then clip
  function automatic int qraw(int c);
    int n;
`ifdef RLE_ROUND_EN
    n = c + 32;
`else
    n = c;
`endif
    return (n >= 0) ? n / 64 : -((-n + 63) / 64);
  endfunction

  function automatic int qclip(int r);
    return (r > 127) ? 127 : ((r < -128) ? -128 : r);
  endfunction

  function automatic void push_exp(bit sel, int r, int v, bit e);
    tok_t t;
    t.run = 3'(r);
    t.val = 8'(v);
    t.eob = e;
    if (sel) exp16.push_back(t);
    else     exp8.push_back(t);
  endfunction

  // Token model: groups of 8 zeros become escapes, remainder is the run
  function automatic void model_frame(bit sel);
    int z = 0;
    int flen = frm.size();
    exp_sat = 0;
    for (int i = 0; i < flen; i++) begin
      int r = qraw(frm[i]);
      int q = qclip(r);
      if (r != q) exp_sat++;
      if (q != 0) begin
        for (int k = 0; k < z / 8; k++) push_exp(sel, 7, 0, 1'b0);
        push_exp(sel, z % 8, q, 1'b0);
        z = 0;
        if (i == flen - 1) push_exp(sel, 0, 0, 1'b1);
      end else begin
        z++;
        if (i == flen - 1) begin
          int esc = (z - 1) / 8;
          int rem = z - esc * 8;
          for (int k = 0; k < esc; k++) push_exp(sel, 7, 0, 1'b0);
          push_exp(sel, (rem > 7) ? 7 : rem, 0, 1'b1);
        end
      end
    end
  endfunction

  function automatic int rnd_coef();
    int b[8] = '{8191, 8192, -8192, -8193, 63, -1, 262143, -262144};
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 0;
      5:             return int'($urandom_range(0, 160)) - 80;
      6, 7:          return int'($urandom_range(0, 6000)) - 3000;
      8:             return int'($urandom_range(0, 524287)) - 262144;
      default:       return b[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one coefficient until accepted; called just after a rising edge
  task automatic send(input bit sel, input int c, input bit rand_bp);
    bit got = 1'b0;
    coef_in = 19'(c);
    if (sel) valid16 = 1'b1;
    else     valid8  = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if ((sel ? rdy16 : rdy8) === 1'b1) got = 1'b1;
      else begin
        stalls++;
        step();
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    step();
    valid8  = 1'b0;
    valid16 = 1'b0;
  endtask

  task automatic start_frame(input bit sel);
    exp8.delete(); exp16.delete(); got8.delete(); got16.delete();
    stalls   = 0;
    sat_base = sel ? satc16 : satc8;
    model_frame(sel);
  endtask

  task automatic finish_frame(input bit sel, input string tag);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    step();
    if (sel) begin
      check({tag, "_ntok"}, got16.size(), exp16.size());
      for (int i = 0; i < got16.size() && i < exp16.size(); i++)
        check({tag, "_tok"}, got16[i], exp16[i]);
      check({tag, "_sat"}, satc16 - sat_base, exp_sat);
    end else begin
      check({tag, "_ntok"}, got8.size(), exp8.size());
      for (int i = 0; i < got8.size() && i < exp8.size(); i++)
        check({tag, "_tok"}, got8[i], exp8[i]);
      check({tag, "_sat"}, satc8 - sat_base, exp_sat);
    end
  endtask

  task automatic run_frame(input bit sel, input bit rand_bp, input string tag);
    start_frame(sel);
    for (int i = 0; i < frm.size(); i++) send(sel, frm[i], rand_bp);
    finish_frame(sel, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1; coef_in = '0; valid8 = 1'b0; valid16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", ov8, 0);
    check("rst_ready", rdy8, 0);
    check("rst_fields", {run8, val8, eob8, sat8}, 0);
    check("rst_valid16", ov16, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", rdy8, 1);
    check("post_rst_ready16", rdy16, 1);
    step();

    // Truncation frame, full throughput
    frm = '{640, 0, 0, -128, 0, 0, 0, 0};
    run_frame(1'b0, 1'b0, "trunc");
    check("trunc_stalls", stalls, 0);

    // Last coefficient nonzero: one EOB_PEND stall cycle
    frm = '{0, 0, 0, 0, 0, 0, 0, 320};
    start_frame(1'b0);
    for (int i = 0; i < 8; i++) send(1'b0, frm[i], 1'b0);
    check("lastnz_stalls", stalls, 0);
    @(negedge clk);
    check("lastnz_ready_low", rdy8, 0);
    @(negedge clk);
    check("lastnz_ready_back", rdy8, 1);
    step();
    finish_frame(1'b0, "lastnz");

    // Saturation both directions
    frm = '{20000, -20000, 0, 0, 0, 0, 0, 0};
    start_frame(1'b0);
    send(1'b0, 20000, 1'b0);
    @(negedge clk);
    check("sat_hi_pulse", sat8, 1);
    check("sat_hi_val", $signed(val8), 127);
    step();
    send(1'b0, -20000, 1'b0);
    @(negedge clk);
    check("sat_lo_pulse", sat8, 1);
    check("sat_lo_val", $signed(val8), -128);
    @(negedge clk);
    check("sat_pulse_end", sat8, 0);
    step();
    for (int i = 2; i < 8; i++) send(1'b0, frm[i], 1'b0);
    finish_frame(1'b0, "sat");

    // Rounding/truncation boundary values
    frm = '{63, 32, -33, 0, 95, -32, 8191, 0};
    run_frame(1'b0, 1'b0, "round");

    // Escape token on the 16-coefficient instance
    frm.delete();
    for (int i = 0; i < 16; i++) frm.push_back((i == 10) ? 320 : 0);
    run_frame(1'b1, 1'b0, "escape");
    frm.delete();
    for (int i = 0; i < 16; i++) frm.push_back(0);
    run_frame(1'b1, 1'b0, "zeros16");

    // Backpressure: token held for 5 cycles, coef_ready low
    frm = '{640, 0, 0, -128, 0, 0, 0, 192};
    start_frame(1'b0);
    out_ready = 1'b0;
    send(1'b0, 640, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", ov8, 1);
      check("bp_tok", {run8, val8, eob8}, {3'd0, 8'd10, 1'b0});
      check("bp_ready", rdy8, 0);
    end
    step();
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) send(1'b0, frm[i], 1'b0);
    finish_frame(1'b0, "bp");

    // Reset mid-frame discards the partial frame
    send(1'b0, 192, 1'b0);
    send(1'b0, 0, 1'b0);
    send(1'b0, 0, 1'b0);
    out_ready = 1'b0;
    send(1'b0, 320, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", ov8, 0);
    check("midrst_ready", rdy8, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", rdy8, 1);
    step();
    frm = '{0, 64, 0, 0, 0, 0, -64, 0};
    run_frame(1'b0, 1'b0, "after_rst");

    // Random frames with random backpressure
    for (int f = 0; f < 30; f++) begin
      frm.delete();
      for (int i = 0; i < 8; i++) frm.push_back(rnd_coef());
      run_frame(1'b0, 1'b1, "rand8");
    end
    for (int f = 0; f < 15; f++) begin
      frm.delete();
      for (int i = 0; i < 16; i++) frm.push_back(($urandom_range(0, 2) == 0) ? rnd_coef() : 0);
      run_frame(1'b1, 1'b1, "rand16");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
